// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared widths, reset PC and fetch FSM encoding
package fetch_sequencer_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int RESET_PC_DEF = 0;
  typedef enum logic [1:0] {ISSUE, READ, HOLD, STORE} state_t;
endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sole master of the memory port; fetches bytes at pc, performs stores, handles irq entry/return
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF,
  parameter bit IEN_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] address1,
  output logic              sta1,
  output logic [DATA_W-1:0] dataout_mp,
  input  logic [DATA_W-1:0] datain_mp,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ack,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              iret,
  input  logic              irq,
  input  logic [ADDR_W-1:0] irq_vec,
  output logic              irq_ack
);
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, epc, epc_n;
  logic ien, ien_n, take_irq, redirect, latch;
  always_comb begin
    take_irq = state == ISSUE && !st_req && irq && ien;
    redirect = jmp_valid || iret;
    latch = state == READ && !redirect;
    // a redirect always restarts at ISSUE, but a STORE in flight still drives the port this cycle
    state_n = redirect ? ISSUE :
              state == ISSUE ? (st_req ? STORE : take_irq ? ISSUE : READ) :
              state == READ ? HOLD :
              state == HOLD ? (ir_ready ? ISSUE : HOLD) : ISSUE;
    pc_n = jmp_valid ? jmp_addr :
           iret ? epc :
           take_irq ? irq_vec :
           state == READ ? pc + ADDR_W'(1) : pc;
    epc_n = take_irq ? pc : epc;
    ien_n = iret ? 1'b1 : take_irq ? 1'b0 : ien;
    sta1 = state == STORE;
    st_ack = state == STORE;
    address1 = state == STORE ? st_addr : pc;
    dataout_mp = state == STORE ? st_data : '0;
    ir_valid = state == HOLD;
    irq_ack = take_irq;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ISSUE;
      pc <= ADDR_W'(RESET_PC);
      epc <= '0;
      ien <= IEN_RESET;
      ir_data <= '0;
      ir_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      epc <= epc_n;
      ien <= ien_n;
      if (latch) begin
        ir_data <= datain_mp;
        ir_pc <= pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized scoreboard bench with a behavioural fetch/store/irq model
module tb_fetch_sequencer;
  logic clk = 0, rst = 1, load = 1;
  logic [3:0] address1, ir_pc, st_addr, jmp_addr, irq_vec;
  logic [7:0] dataout_mp, datain_mp, ir_data, st_data;
  logic sta1, ir_valid, ir_ready, st_req, st_ack, jmp_valid, iret, irq, irq_ack;
  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .address1(address1), .sta1(sta1), .dataout_mp(dataout_mp),
    .datain_mp(datain_mp), .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc),
    .ir_ready(ir_ready), .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
    .st_ack(st_ack), .jmp_valid(jmp_valid), .jmp_addr(jmp_addr), .iret(iret),
    .irq(irq), .irq_vec(irq_vec), .irq_ack(irq_ack)
  );

  function automatic logic [7:0] img(int i);
    case (i)
      0: return 8'h51;
      1: return 8'h07;
      2: return 8'h4C;
      3: return 8'h64;
      8: return 8'h85;
      15: return 8'h2D;
      default: return 8'(i * 29 + 3);
    endcase
  endfunction

  // synchronous-read memory: address presented in ISSUE is visible on datain_mp during READ
  logic [7:0] mem[16];
  always @(posedge clk) begin
    if (load) for (int i = 0; i < 16; i++) mem[i] <= img(i);
    else if (sta1) mem[address1] <= dataout_mp;
    datain_mp <= mem[address1];
  end

  typedef struct {logic [7:0] d; logic [3:0] a;} pair_t;
  pair_t fq[$], sq[$];
  logic [3:0] iq[$];
  logic [7:0] mm[16];
  logic [3:0] m_pc, m_epc;
  logic m_ien;
  int checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(string name, string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic void push_fetch();
    fq.push_back('{mm[m_pc], m_pc});
    m_pc = m_pc + 4'd1;
  endfunction

  logic pv;
  logic [7:0] pd;
  logic [3:0] pp;
  always @(negedge clk) begin
    if (rst) pv <= 0;
    else begin
      if (ir_valid && !pv) begin
        if (fq.size() == 0) fail("fetch_unexpected", $sformatf("got ir_pc %0h, expected no byte", ir_pc));
        else begin
          pair_t e;
          e = fq.pop_front();
          chk("ir_data", ir_data, e.d);
          chk("ir_pc", ir_pc, e.a);
        end
      end
      if (ir_valid && pv) begin
        chk("ir_data_stable", ir_data, pd);
        chk("ir_pc_stable", ir_pc, pp);
      end
      chk("st_ack_eq_sta1", st_ack, sta1);
      if (sta1) begin
        if (sq.size() == 0) fail("store_unexpected", $sformatf("got store to %0h, expected none", address1));
        else begin
          pair_t s;
          s = sq.pop_front();
          chk("store_addr", address1, s.a);
          chk("store_data", dataout_mp, s.d);
        end
      end else chk("dataout_idle", dataout_mp, 0);
      if (irq_ack) begin
        if (iq.size() == 0) fail("irq_unexpected", $sformatf("got irq_ack at pc %0h, expected none", address1));
        else chk("irq_epc", address1, iq.pop_front());
      end
      pv <= ir_valid;
      pd <= ir_data;
      pp <= ir_pc;
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (st_ack) st_req = 0;
      if (ir_valid) break;
      if (n >= 50) begin
        fail("wait_valid", "got no ir_valid within 50 cycles, expected a byte");
        break;
      end
    end
  endtask

  task automatic do_reset();
    int n;
    rst = 1; ir_ready = 0; st_req = 0; jmp_valid = 0; iret = 0; irq = 0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {ir_valid, sta1, st_ack, irq_ack, dataout_mp, ir_data, ir_pc, address1}, 0);
    m_pc = 0; m_epc = 0; m_ien = 1;
    push_fetch();
    @(posedge clk);
    #1 rst = 0; load = 0;
    wait_valid(n);
    chk("first_fetch_cycle", n, 3);
    chk("first_fetch_pc", ir_pc, 0);
  endtask

  task automatic accept(bit st, logic [3:0] a, logic [7:0] d, bit rq, logic [3:0] v);
    int n;
    bit taken;
    taken = rq && m_ien;
    if (st) begin mm[a] = d; sq.push_back('{d, a}); end
    if (taken) begin iq.push_back(m_pc); m_epc = m_pc; m_pc = v; m_ien = 0; end
    push_fetch();
    ir_ready = 1; st_req = st; st_addr = a; st_data = d; irq = rq; irq_vec = v;
    @(posedge clk);
    #1 ir_ready = 0;
    wait_valid(n);
    irq = 0;
    chk("accept_latency", n, 3 + 2 * int'(st) + int'(taken));
  endtask

  task automatic redirect(bit j, bit r, logic [3:0] a);
    int n;
    m_pc = j ? a : m_epc;
    if (r) m_ien = 1;
    push_fetch();
    jmp_valid = j; iret = r; jmp_addr = a;
    @(posedge clk);
    #1 jmp_valid = 0; iret = 0;
    wait_valid(n);
    chk("redirect_latency", n, 3);
  endtask

  task automatic idle(int k);
    repeat (k) begin
      @(negedge clk);
      chk("hold_valid", ir_valid, 1);
      chk("hold_addr", address1, m_pc);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mm[i] = img(i);
    st_addr = 0; st_data = 0; jmp_addr = 0; irq_vec = 0;
    do_reset();
    chk("t1_byte0", ir_data, 8'h51);
    idle(5);
    chk("t2_stall_data", ir_data, 8'h51);
    accept(0, 0, 0, 0, 0);
    chk("t1_byte1", ir_data, 8'h07);
    accept(0, 0, 0, 1, 8);
    chk("t4_vector_byte", ir_data, 8'h85);
    accept(0, 0, 0, 1, 4);
    chk("t4_irq_ignored_pc", ir_pc, 9);
    redirect(0, 1, 0);
    chk("t4_iret_byte", ir_data, 8'h4C);
    accept(0, 0, 0, 1, 8);
    accept(1, 3, 8'hA5, 0, 0);
    redirect(1, 0, 3);
    chk("t3_stored_byte", ir_data, 8'hA5);
    redirect(0, 1, 0);
    redirect(1, 0, 15);
    chk("t5_byte15", ir_data, 8'h2D);
    accept(0, 0, 0, 0, 0);
    chk("t5_wrap_data", ir_data, 8'h51);
    chk("t5_wrap_pc", ir_pc, 0);
    redirect(1, 1, 5);
    for (int i = 0; i < 120; i++) begin
      int k;
      logic [3:0] a, v;
      logic [7:0] d;
      k = $urandom_range(0, 9);
      a = 4'($urandom); v = 4'($urandom); d = 8'($urandom);
      if (k < 6) accept($urandom_range(0, 2) == 0, a, d, $urandom_range(0, 2) == 0, v);
      else if (k == 6) redirect(1, 0, a);
      else if (k == 7) redirect(0, 1, a);
      else if (k == 8) redirect(1, 1, a);
      else idle($urandom_range(1, 4));
    end
    #2 rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_hold_reset", {ir_valid, sta1, st_ack}, 0);
    do_reset();
    mm[6] = 8'h3C;
    sq.push_back('{8'h3C, 4'd6});
    ir_ready = 1; st_req = 1; st_addr = 6; st_data = 8'h3C;
    @(posedge clk);
    #1 ir_ready = 0;
    for (int i = 0; i < 10 && !sta1; i++) @(negedge clk);
    if (!sta1) fail("t6_store_seen", "got no sta1, expected a store");
    #2 rst = 1; st_req = 0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_store_reset", {ir_valid, sta1, st_ack}, 0);
    do_reset();
    redirect(1, 0, 6);
    chk("t6_store_kept", ir_data, 8'h3C);
    repeat (2) @(negedge clk);
    chk("fetch_queue_empty", fq.size(), 0);
    chk("store_queue_empty", sq.size(), 0);
    chk("irq_queue_empty", iq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
